oam_dma_ctrl: RTL

Sprite (OAM) DMA controller for the 2A03 model. It sits between the 6502 core and the system bus. A CPU write to $4014 halts the core through RDY, and the block takes the bus. It then copies 256 bytes from CPU page $XX00-$XXFF to PPU register $2004 as alternating read/write cycles aligned to the APU get/put parity. The transfer takes 513 or 514 cycles, as on silicon.

---
 rtl/oam_dma_ctrl.sv | 136 +++++++++++++
 1 files changed

// File: rtl/oam_dma_ctrl.sv
// Sprite (OAM) DMA controller: a CPU write to DMA_REG halts the core and copies one
// 256-byte page to OAM_PORT as read/write pairs aligned to the get/put parity.
module oam_dma_ctrl #(
  parameter logic [15:0] DMA_REG  = 16'h4014,
  parameter logic [15:0] OAM_PORT = 16'h2004
) (
  input  logic        CLK,
  input  logic        n_RES,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_rw,
  input  logic [7:0]  cpu_dout,
  input  logic [7:0]  data_in,
  output logic        RDY,
  output logic        bus_sel,
  output logic [15:0] dma_addr,
  output logic        dma_rw,
  output logic [7:0]  dma_dout,
  output logic        dma_active
);

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned BYTE_W = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HALT,
    S_ALIGN,
    S_READ,
    S_WRITE
  } state_t;

  state_t              r_state;
  logic                r_odd;
  logic [BYTE_W-1:0]   r_idx;
  logic [BYTE_W-1:0]   r_page;
  logic [BYTE_W-1:0]   r_latch;
  logic                r_rdy;
  logic                r_bus_sel;
  logic [ADDR_W-1:0]   r_dma_addr;
  logic                r_dma_rw;
  logic [BYTE_W-1:0]   r_dma_dout;
  logic                r_dma_active;

  state_t              w_state_d;
  logic [BYTE_W-1:0]   w_idx_d;
  logic [BYTE_W-1:0]   w_page_d;
  logic [BYTE_W-1:0]   w_latch_d;
  logic                w_rdy_d;
  logic                w_bus_sel_d;
  logic [ADDR_W-1:0]   w_dma_addr_d;
  logic                w_dma_rw_d;
  logic [BYTE_W-1:0]   w_dma_dout_d;
  logic                w_dma_active_d;

  // Next-state logic; outputs are decoded from the next state so they register as Moore outputs.
  always_comb begin
    w_state_d = r_state;
    w_idx_d   = r_idx;
    w_page_d  = r_page;
    w_latch_d = r_latch;

    unique case (r_state)
      S_IDLE: begin
        if (!cpu_rw && (cpu_addr == DMA_REG)) begin
          w_state_d = S_HALT;
          w_page_d  = cpu_dout;
          w_idx_d   = '0;
        end
      end
      S_HALT: begin
        if (cpu_rw) begin
          w_state_d = r_odd ? S_READ : S_ALIGN;
        end
      end
      S_ALIGN: w_state_d = S_READ;
      S_READ: begin
        w_latch_d = data_in;
        w_state_d = S_WRITE;
      end
      S_WRITE: begin
        w_idx_d   = r_idx + BYTE_W'(1);
        w_state_d = (r_idx == 8'hFF) ? S_IDLE : S_READ;
      end
      default: w_state_d = S_IDLE;
    endcase

    w_rdy_d        = (w_state_d == S_IDLE);
    w_dma_active_d = (w_state_d != S_IDLE);
    w_bus_sel_d    = (w_state_d == S_READ) || (w_state_d == S_WRITE);
    w_dma_rw_d     = (w_state_d != S_WRITE);
    w_dma_addr_d   = '0;
    w_dma_dout_d   = '0;
    if (w_state_d == S_READ) begin
      w_dma_addr_d = {w_page_d, w_idx_d};
    end else if (w_state_d == S_WRITE) begin
      w_dma_addr_d = OAM_PORT;
      w_dma_dout_d = w_latch_d;
    end
  end

  always_ff @(posedge CLK or negedge n_RES) begin
    if (!n_RES) begin
      r_state      <= S_IDLE;
      r_odd        <= 1'b0;
      r_idx        <= '0;
      r_page       <= '0;
      r_latch      <= '0;
      r_rdy        <= 1'b1;
      r_bus_sel    <= 1'b0;
      r_dma_addr   <= '0;
      r_dma_rw     <= 1'b1;
      r_dma_dout   <= '0;
      r_dma_active <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_odd        <= ~r_odd;
      r_idx        <= w_idx_d;
      r_page       <= w_page_d;
      r_latch      <= w_latch_d;
      r_rdy        <= w_rdy_d;
      r_bus_sel    <= w_bus_sel_d;
      r_dma_addr   <= w_dma_addr_d;
      r_dma_rw     <= w_dma_rw_d;
      r_dma_dout   <= w_dma_dout_d;
      r_dma_active <= w_dma_active_d;
    end
  end

  assign RDY        = r_rdy;
  assign bus_sel    = r_bus_sel;
  assign dma_addr   = r_dma_addr;
  assign dma_rw     = r_dma_rw;
  assign dma_dout   = r_dma_dout;
  assign dma_active = r_dma_active;

endmodule
